// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared state encodings and widths for the breakout sequencer
//
// Holds the game-phase encoding used by the sequencer and any display/overlay
// logic that decodes STATE, plus the widths of the lives and frame-timer
// registers so every consumer sizes its buses the same way.
// No ports (package).

package breakout_pkg;

    localparam int LIVES_W = 4;
    localparam int TIMER_W = 8;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Encoding 7 is never entered; the sequencer treats it exactly like IDLE.
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_SERVE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSED = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOST   = 3'd4;
    localparam logic [STATE_W-1:0] ST_OVER   = 3'd5;
    localparam logic [STATE_W-1:0] ST_WON    = 3'd6;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 8-bit saturating frame counter with synchronous clear
//
// Counts video frames spent in the current game phase.
// Ports:
//   i_clk         in   system clock, rising edge
//   i_rst         in   synchronous active-high reset (count -> 0)
//   i_clear       in   synchronous clear, wins over i_inc
//   i_inc         in   FRAME_START pulse, adds one frame
//   o_count       out  registered frame count
//   o_count_next  out  count as it will stand after this cycle's i_inc
//                      (ignoring i_clear), so the parent can act on the
//                      frame that reaches a limit without a cycle of lag

module frame_timer
    import breakout_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_inc,
    output logic [TIMER_W-1:0] o_count,
    output logic [TIMER_W-1:0] o_count_next
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] w_count_sat;

    // Hold at all-ones instead of wrapping so long stays read as "long".
    assign w_count_sat  = (r_count == {TIMER_W{1'b1}}) ? r_count
                                                        : r_count + {{(TIMER_W-1){1'b0}}, 1'b1};
    assign o_count_next = i_inc ? w_count_sat : r_count;
    assign o_count      = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_count_sat;
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - breakout game phase sequencer and frame update strobe
//
// Tracks the game phase and lives, issues one START_UPDATE per frame while the
// paddle/ball logic should run, and gates ball motion.
// Ports:
//   CLK             in   system clock, rising edge
//   RST             in   synchronous active-high reset
//   FRAME_START     in   one-cycle pulse per video frame
//   BTN_START       in   debounced start/pause button (level)
//   BALL_LOST       in   one-cycle pulse, ball fell below paddle
//   BRICKS_CLEARED  in   one-cycle pulse, last brick destroyed
//   START_UPDATE    out  one-cycle game-logic launch, SERVE/PLAY frames only
//   BALL_ENABLE     out  high while in PLAY
//   RESET_BALL      out  one-cycle pulse, re-centre ball on paddle
//   RESET_FIELD     out  one-cycle pulse, restore all bricks
//   LIVES           out  remaining lives
//   STATE           out  current phase encoding

module game_state_controller
    import breakout_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90,
    parameter int END_FRAMES   = 180
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FRAME_START,
    input  logic               BTN_START,
    input  logic               BALL_LOST,
    input  logic               BRICKS_CLEARED,
    output logic               START_UPDATE,
    output logic               BALL_ENABLE,
    output logic               RESET_BALL,
    output logic               RESET_FIELD,
    output logic [LIVES_W-1:0] LIVES,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [TIMER_W-1:0] SERVE_CNT  = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] LOST_CNT   = TIMER_W'(LOST_FRAMES);
    localparam logic [TIMER_W-1:0] END_CNT    = TIMER_W'(END_FRAMES);

    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic               r_btn_prev;
    logic               r_start_update;
    logic               r_ball_enable;
    logic               r_reset_ball;
    logic               r_reset_field;

    state_t             w_next_state;
    logic [LIVES_W-1:0] w_next_lives;
    logic               w_set_reset_ball;
    logic               w_set_reset_field;
    logic               w_start_edge;
    logic               w_state_change;
    logic               w_in_active;
    logic [TIMER_W-1:0] w_count;
    logic [TIMER_W-1:0] w_count_next;

    // The previous-button register comes out of reset high, so a button that
    // is already held when reset releases must be let go before it counts.
    assign w_start_edge   = BTN_START & ~r_btn_prev;
    assign w_state_change = (w_next_state != r_state);
    assign w_in_active    = (r_state == ST_SERVE) || (r_state == ST_PLAY);

    frame_timer u_frame_timer (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_clear      (w_state_change),
        .i_inc        (FRAME_START),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    always_comb begin
        w_next_state      = r_state;
        w_next_lives      = r_lives;
        w_set_reset_ball  = 1'b0;
        w_set_reset_field = 1'b0;

        case (r_state)
            ST_SERVE: begin
                // Timed exits look at the post-increment count so the frame
                // that reaches the limit moves the state on the next cycle.
                if (w_start_edge || (w_count_next == SERVE_CNT)) begin
                    w_next_state = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (BRICKS_CLEARED) begin
                    w_next_state = ST_WON;
                end else if (BALL_LOST) begin
                    // <= 1 rather than == 1 so lives can never wrap below 0.
                    if (r_lives <= LIVES_ONE) begin
                        w_next_lives = '0;
                        w_next_state = ST_OVER;
                    end else begin
                        w_next_lives = r_lives - LIVES_ONE;
                        w_next_state = ST_LOST;
                    end
                end else if (w_start_edge) begin
                    w_next_state = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (w_start_edge) begin
                    w_next_state = ST_PLAY;
                end
            end

            ST_LOST: begin
                if (w_count_next == LOST_CNT) begin
                    w_next_state     = ST_SERVE;
                    w_set_reset_ball = 1'b1;
                end
            end

            ST_OVER, ST_WON: begin
                // The end screen must stay up for END_FRAMES completed frames
                // before a press is accepted; earlier presses are dropped.
                if (w_start_edge && (w_count >= END_CNT)) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                // IDLE and the unused encoding: a press starts a new game.
                if (w_start_edge) begin
                    w_next_state      = ST_SERVE;
                    w_next_lives      = LIVES_LOAD;
                    w_set_reset_ball  = 1'b1;
                    w_set_reset_field = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_lives        <= '0;
            r_btn_prev     <= 1'b1;
            r_start_update <= 1'b0;
            r_ball_enable  <= 1'b0;
            r_reset_ball   <= 1'b0;
            r_reset_field  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_lives        <= w_next_lives;
            r_btn_prev     <= BTN_START;
            // Gated by the phase the frame arrived in, not the one it causes.
            r_start_update <= FRAME_START & w_in_active;
            r_ball_enable  <= (w_next_state == ST_PLAY);
            r_reset_ball   <= w_set_reset_ball;
            r_reset_field  <= w_set_reset_field;
        end
    end

    assign STATE        = r_state;
    assign LIVES        = r_lives;
    assign START_UPDATE = r_start_update;
    assign BALL_ENABLE  = r_ball_enable;
    assign RESET_BALL   = r_reset_ball;
    assign RESET_FIELD  = r_reset_field;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - self-checking bench for game_state_controller

module tb_game_state_controller;
    import breakout_pkg::*;

    typedef struct {
        logic       fs;
        logic       btn;
        logic       lost;
        logic       clr;
        logic [2:0] st;
        logic [3:0] lv;
        logic       su;
        logic       be;
        logic       rb;
        logic       rf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       btn_start;
    logic       ball_lost;
    logic       bricks_cleared;
    logic       start_update;
    logic       ball_enable;
    logic       reset_ball;
    logic       reset_field;
    logic [3:0] lives;
    logic [2:0] state;

    int n_cmp   = 0;
    int n_fail  = 0;
    int su_seen = 0;
    int su_base;

    vec_t vecs [0:7];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_update === 1'b1) su_seen++;
    end

    game_state_controller #(
        .LIVES_INIT   (3),
        .SERVE_FRAMES (60),
        .LOST_FRAMES  (90),
        .END_FRAMES   (180)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .FRAME_START    (frame_start),
        .BTN_START      (btn_start),
        .BALL_LOST      (ball_lost),
        .BRICKS_CLEARED (bricks_cleared),
        .START_UPDATE   (start_update),
        .BALL_ENABLE    (ball_enable),
        .RESET_BALL     (reset_ball),
        .RESET_FIELD    (reset_field),
        .LIVES          (lives),
        .STATE          (state)
    );

    task automatic drive(input logic fs, input logic btn, input logic lost, input logic clr);
        frame_start    = fs;
        btn_start      = btn;
        ball_lost      = lost;
        bricks_cleared = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] lv,
                         input logic su, input logic be, input logic rb, input logic rf);
        logic [10:0] got;
        logic [10:0] exp;
        got = {state, lives, start_update, ball_enable, reset_ball, reset_field};
        exp = {st, lv, su, be, rb, rf};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: state/lives/su/be/rb/rf got %0d/%0d/%b%b%b%b want %0d/%0d/%b%b%b%b",
                     name, $time, state, lives, start_update, ball_enable, reset_ball, reset_field,
                     st, lv, su, be, rb, rf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // n frame pulses, each followed by an idle cycle, with the phase held.
    task automatic frames(input int n, input logic [2:0] st, input logic [3:0] lv,
                          input logic su, input logic be);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("frame", st, lv, su, be, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check("frame_gap", st, lv, 1'b0, be, 1'b0, 1'b0);
        end
    endtask

    initial begin
        //         fs    btn   lost  clr   state     lv su be rb rf
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,  0, 0, 0, 0, 0}; // held through reset
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_IDLE,  0, 0, 0, 0, 0}; // no update in IDLE
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,  0, 0, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,  0, 0, 0, 0, 0}; // lost ignored
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_SERVE, 3, 0, 0, 1, 1}; // new game
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_SERVE, 3, 1, 0, 0, 0}; // serve frame 1
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_SERVE, 3, 0, 0, 0, 0}; // events ignored
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_SERVE, 3, 0, 0, 0, 0};

        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_state", ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        su_base = su_seen;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].fs, vecs[i].btn, vecs[i].lost, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv,
                  vecs[i].su, vecs[i].be, vecs[i].rb, vecs[i].rf);
        end

        // Serve frames 2..59, then the 60th launches the ball.
        frames(58, ST_SERVE, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("serve_launch", ST_PLAY, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("play_idle", ST_PLAY, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_int("serve_update_count", su_seen - su_base, 60);

        // Two lives lost with the full LOST hold, re-serve by button each time.
        for (int k = 2; k >= 1; k--) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            check("ball_lost", ST_LOST, 4'(k), 1'b0, 1'b0, 1'b0, 1'b0);
            frames(89, ST_LOST, 4'(k), 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("lost_expire", ST_SERVE, 4'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            check("serve_press", ST_PLAY, 4'(k), 1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check("replay", ST_PLAY, 4'(k), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        su_base = su_seen;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("last_life", ST_OVER, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(100, ST_OVER, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("over_press_100", ST_OVER, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(79, ST_OVER, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("over_press_179", ST_OVER, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        frames(1, ST_OVER, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("over_press_180", ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_int("over_update_count", su_seen - su_base, 0);

        // Second game: clear and lose in the same cycle -> WON wins.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("game2_start", ST_SERVE, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("game2_launch", ST_PLAY, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("clear_and_lost", ST_WON, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(180, ST_WON, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("won_exit", ST_IDLE, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Third game: pause with frames running and a stray ball-lost pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("game3_start", ST_SERVE, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("game3_launch", ST_PLAY, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause", ST_PAUSED, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        su_base = su_seen;
        frames(10, ST_PAUSED, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("paused_lost_ignored", ST_PAUSED, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("resume", ST_PLAY, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_int("paused_update_count", su_seen - su_base, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_frame", ST_PLAY, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-play with a frame pulse in flight.
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_reset", ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset", ST_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Top-level sequencer for the breakout game. It tracks the game phase (attract, serve, play, pause, ball lost, game over, won) and the lives count. Once per video frame it issues the single-cycle START_UPDATE strobe that launches the paddle/ball update logic, and it gates ball motion. It sits between the VGA timing generator (frame pulse), the debounced buttons and the game-logic/collision blocks.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded at game start (1..15).
- SERVE_FRAMES, 60: frames in SERVE before auto-launch (1..255).
- LOST_FRAMES, 90: frames held in LOST before re-serve (1..255).
- END_FRAMES, 180: minimum frames in OVER/WON before returning to IDLE (1..255).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- FRAME_START  in  1  one-cycle pulse per video frame, from timing generator.
- BTN_START  in  1  debounced start/pause button, level.
- BALL_LOST  in  1  one-cycle pulse: ball passed below paddle.
- BRICKS_CLEARED  in  1  one-cycle pulse: last brick destroyed.
- START_UPDATE  out  1  one-cycle update launch to game logic.
- BALL_ENABLE  out  1  ball may move; high only in PLAY.
- RESET_BALL  out  1  one-cycle pulse: re-centre ball on paddle.
- RESET_FIELD  out  1  one-cycle pulse: restore all bricks.
- LIVES  out  4  remaining lives.
- STATE  out  3  current state encoding, for display/overlay.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, LOST=4, OVER=5, WON=6. 7 is unreachable; it decodes as IDLE.
- Start edge: rising edge of BTN_START. The previous-value register resets to 1, so a button held through reset yields no edge.
- IDLE: on a start edge, go to SERVE. Load LIVES=LIVES_INIT and pulse RESET_FIELD and RESET_BALL.
- SERVE: on frame timer == SERVE_FRAMES, or on a start edge, go to PLAY.
- PLAY: precedence is BRICKS_CLEARED > BALL_LOST > start edge.
  - BRICKS_CLEARED: go to WON.
  - BALL_LOST with LIVES==1: LIVES=0, go to OVER.
  - BALL_LOST with LIVES>1: LIVES-1, go to LOST.
  - Start edge: go to PAUSED.
- PAUSED: on a start edge, return to PLAY. The frame timer is untouched.
- LOST: on timer == LOST_FRAMES, pulse RESET_BALL and go to SERVE.
- OVER/WON: on a start edge with timer ≥ END_FRAMES, go to IDLE.
  - Entering IDLE performs no field reset; the next game start does.
  - Start edges before END_FRAMES are ignored.
- BALL_LOST and BRICKS_CLEARED are ignored outside PLAY.
- Frame timer:
  - 8-bit; cleared on every state change.
  - Increments on FRAME_START.
  - Saturates at 255.
- START_UPDATE: pulses for each FRAME_START sampled while in SERVE or PLAY (paddle moves during serve). It does not pulse in IDLE, PAUSED, LOST, OVER or WON.
- LIVES never underflows or wraps.

## Timing
- All outputs are registered.
- Reset values: STATE=IDLE, LIVES=0, START_UPDATE=0, BALL_ENABLE=0, RESET_BALL=0, RESET_FIELD=0, timer=0.
- FRAME_START at cycle t gives START_UPDATE high for cycle t+1 only.
  - Gating uses the state held at cycle t.
  - A transition also caused at t does not suppress or add a pulse.
- An event or start edge sampled at t gives the new STATE, LIVES and reset pulses at t+1.
- BTN_START at cycle t is registered as the previous value; an edge is detected at t when BTN_START(t)=1 and prev=0.
- Timer-driven exits: the FRAME_START that makes the count reach N at t causes the transition at t+1.
- RST mid-game: all state returns to reset values at the next edge, and any in-flight pulse is dropped.

## Structure
- Shared package breakout_pkg holds:
  - the state type and encodings;
  - the LIVES and frame-timer widths.
- Sub-module frame_timer: 8-bit saturating frame counter with synchronous clear and FRAME_START increment.
- Parent holds:
  - the FSM;
  - lives register;
  - start-edge detector;
  - output pulse registers.

## Test plan
- Reset with BTN_START held high, then release and press: no transition on the first high. After the press, STATE=1, LIVES=3, and RESET_FIELD and RESET_BALL each pulse for exactly 1 cycle.
- SERVE with 60 FRAME_STARTs: START_UPDATE pulses 60 times, one cycle after each FRAME_START. STATE=2 and BALL_ENABLE=1 one cycle after the 60th.
- In PLAY, BALL_LOST ×3 with LOST_FRAMES elapsed between them: LIVES goes 2, 1, 0; states LOST, SERVE, PLAY twice, then OVER. In OVER there is no START_UPDATE and no ball enable.
- In PLAY, BRICKS_CLEARED and BALL_LOST in the same cycle: STATE=6 and LIVES unchanged.
- PLAY, press start, apply 10 FRAME_STARTs, press again: STATE 3 then 2, with zero START_UPDATE pulses while paused.
- In OVER, press start at frame 100 and again at frame 180: the first press is ignored, the second gives STATE=0. Assert RST mid-PLAY: all outputs at reset values on the next cycle.
